// File: rtl/alu_sweep_ctrl.sv
// Sweeps all eight opcodes of the 8-bit ALU for one latched operand pair. Each result is
// offered on a valid/ready stream, and a checksum is kept over the sweep.
module alu_sweep_ctrl #(
  parameter int unsigned SETTLE = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [7:0]  op_a,
  input  logic [7:0]  op_b,
  input  logic [7:0]  alu_out,
  input  logic        alu_c,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  output logic [2:0]  alu_sel,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [7:0]  res_data,
  output logic        res_carry,
  output logic [2:0]  res_sel,
  output logic        busy,
  output logic        done,
  output logic [11:0] checksum
);

  localparam int DATA_W = 8;
  localparam int CSUM_W = 12;
  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);
  localparam logic [2:0] SEL_LAST    = 3'd7;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DRIVE  = 2'd1,
    S_OFFER  = 2'd2,
    S_FINISH = 2'd3
  } state_t;

  state_t     state_q;
  state_t     state_d;
  logic [3:0] settle_q;
  logic       accept;
  logic       capture;
  logic       advance;

  // A full sweep adds at most 8 x 511 = 4088, so the 12-bit sum never wraps.
  function automatic logic [CSUM_W-1:0] csum_add(
    input logic [CSUM_W-1:0] acc,
    input logic              carry,
    input logic [DATA_W-1:0] data
  );
    return acc + {{(CSUM_W - DATA_W - 1){1'b0}}, carry, data};
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // res_valid is high exactly in OFFER, so res_ready alone completes the handshake there.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    capture = 1'b0;
    advance = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          accept  = 1'b1;
          state_d = S_DRIVE;
        end
      end
      S_DRIVE: begin
        if (settle_q == SETTLE_LAST) begin
          capture = 1'b1;
          state_d = S_OFFER;
        end
      end
      S_OFFER: begin
        if (res_ready) begin
          if (alu_sel == SEL_LAST) begin
            state_d = S_FINISH;
          end else begin
            advance = 1'b1;
            state_d = S_DRIVE;
          end
        end
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      settle_q <= 4'd0;
    end else if (accept || advance) begin
      settle_q <= 4'd0;
    end else if (state_q == S_DRIVE) begin
      settle_q <= settle_q + 4'd1;
    end
  end

  // Operand / opcode stage: drives the ALU for the whole sweep.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a   <= 8'd0;
      alu_b   <= 8'd0;
      alu_sel <= 3'd0;
    end else if (accept) begin
      alu_a   <= op_a;
      alu_b   <= op_b;
      alu_sel <= 3'd0;
    end else if (advance) begin
      alu_sel <= alu_sel + 3'd1;
    end
  end

  // Capture stage: results are loaded only on the settle edge and held through backpressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_data  <= 8'd0;
      res_carry <= 1'b0;
      res_sel   <= 3'd0;
      checksum  <= 12'd0;
    end else if (accept) begin
      checksum  <= 12'd0;
    end else if (capture) begin
      res_data  <= alu_out;
      res_carry <= alu_c;
      res_sel   <= alu_sel;
      checksum  <= csum_add(checksum, alu_c, alu_out);
    end
  end

  assign res_valid = (state_q == S_OFFER);
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_FINISH);

endmodule

// File: tb/tb_alu_sweep_ctrl.sv
// Scoreboard bench for alu_sweep_ctrl: two instances (SETTLE 1 and 3), each driving a
// behavioural ALU; expected results are queued at start and popped by per-instance monitors.
`timescale 1ns/1ps
module tb_alu_sweep_ctrl;

  typedef struct packed {
    logic [7:0] d;
    logic       c;
    logic [2:0] s;
  } res_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n [2];
  logic        st    [2];
  logic [7:0]  oa    [2];
  logic [7:0]  ob    [2];
  logic [7:0]  aa    [2];
  logic [7:0]  ab    [2];
  logic [2:0]  as    [2];
  logic [7:0]  ao    [2];
  logic        ac    [2];
  logic        rv    [2];
  logic        rr    [2];
  logic [7:0]  rd    [2];
  logic        rc    [2];
  logic [2:0]  rs    [2];
  logic        bz    [2];
  logic        dn    [2];
  logic [11:0] cs    [2];
  int          amode [2];
  int          rmode [2];

  res_t        exp_q  [2][$];
  logic [11:0] csum_q [2][$];

  int vectors     = 0;
  int miscompares = 0;

  // ALU behaviour: mode 0 is the stub, otherwise a small 8-op ALU with opcode 0 = add.
  function automatic logic [8:0] alu_fn(input int mode, input logic [7:0] a, input logic [7:0] b,
                                        input logic [2:0] s);
    logic [8:0] r;
    if (mode == 0) begin
      r = {s[0], s, 5'b0};
    end else begin
      case (s)
        3'd0:    r = {1'b0, a} + {1'b0, b};
        3'd1:    r = {1'b0, a} - {1'b0, b};
        3'd2:    r = {1'b0, a & b};
        3'd3:    r = {1'b0, a | b};
        3'd4:    r = {1'b0, a ^ b};
        3'd5:    r = {1'b0, ~a};
        3'd6:    r = {a, 1'b0};
        default: r = {a[0], 1'b0, a[7:1]};
      endcase
    end
    return r;
  endfunction

  function automatic int settle_of(input int g);
    return (g == 0) ? 1 : 3;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_dut
    assign {ac[g], ao[g]} = alu_fn(amode[g], aa[g], ab[g], as[g]);

    alu_sweep_ctrl #(.SETTLE((g == 0) ? 1 : 3)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n[g]),
      .start     (st[g]),
      .op_a      (oa[g]),
      .op_b      (ob[g]),
      .alu_out   (ao[g]),
      .alu_c     (ac[g]),
      .alu_a     (aa[g]),
      .alu_b     (ab[g]),
      .alu_sel   (as[g]),
      .res_valid (rv[g]),
      .res_ready (rr[g]),
      .res_data  (rd[g]),
      .res_carry (rc[g]),
      .res_sel   (rs[g]),
      .busy      (bz[g]),
      .done      (dn[g]),
      .checksum  (cs[g])
    );
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // kind 0: idle; kind 1: offering sel; kind 2: driving sel (busy, no offer yet)
  task automatic wait_until(input int g, input int kind, input logic [2:0] sel, input string what);
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      case (kind)
        0:       if (!bz[g]) return;
        1:       if (rv[g] && rs[g] == sel) return;
        default: if (bz[g] && !rv[g] && as[g] == sel) return;
      endcase
    end
    vectors++;
    miscompares++;
    $display("FAIL g%0d wait_%s: not reached in 400 cycles, expected reached", g, what);
  endtask

  task automatic issue(input int g, input logic [7:0] a, input logic [7:0] b, input int mode);
    logic [11:0] sum;
    logic [8:0]  r;
    sum = 12'd0;
    wait_until(g, 0, 3'd0, "idle");
    @(posedge clk); #1;
    amode[g] = mode;
    st[g]    = 1'b1;
    oa[g]    = a;
    ob[g]    = b;
    for (int s = 0; s < 8; s++) begin
      r = alu_fn(mode, a, b, 3'(s));
      exp_q[g].push_back({r[7:0], r[8], 3'(s)});
      sum += {3'b0, r};
    end
    csum_q[g].push_back(sum);
    @(posedge clk); #1;
    st[g] = 1'b0;
    oa[g] = 8'($urandom);
    ob[g] = 8'($urandom);
  endtask

  task automatic ready_drv(input int g);
    forever begin
      @(posedge clk); #1;
      case (rmode[g])
        0:       rr[g] = 1'b1;
        1:       rr[g] = 1'($urandom_range(0, 1));
        default: rr[g] = 1'b0;
      endcase
    end
  endtask

  task automatic monitor(input int g);
    logic        pv, pr, pbz, phs7;
    logic [11:0] pd;
    logic [7:0]  pa, pb;
    logic [2:0]  psel;
    int          since;
    res_t        e;
    pv = 0; pr = 0; pbz = 0; phs7 = 0; pd = 0; pa = 0; pb = 0; psel = 0; since = 0;
    forever begin
      @(negedge clk);
      if (!rst_n[g]) begin
        pv = 0; pbz = 0; phs7 = 0; since = 0;
      end else begin
        if (bz[g] && (!pbz || as[g] != psel)) since = 0;
        else since++;
        if (pv && !pr)
          check($sformatf("g%0d stall_hold", g), 64'({rv[g], rd[g], rc[g], rs[g]}), 64'({1'b1, pd}));
        if (rv[g] && !pv)
          check($sformatf("g%0d settle_cycles", g), 64'(since), 64'(settle_of(g)));
        if (bz[g] && pbz)
          check($sformatf("g%0d operand_hold", g), 64'({aa[g], ab[g]}), 64'({pa, pb}));
        if (rv[g] && rr[g]) begin
          if (exp_q[g].size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL g%0d offer: got sel %0d, expected no offer", g, rs[g]);
          end else begin
            e = exp_q[g].pop_front();
            check($sformatf("g%0d offer{data,carry,sel}", g), 64'({rd[g], rc[g], rs[g]}), 64'(e));
          end
        end
        if (dn[g]) begin
          check($sformatf("g%0d done_after_last", g), 64'(phs7), 64'(1));
          if (csum_q[g].size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL g%0d checksum: got done with 0x%0h, expected no done", g, cs[g]);
          end else begin
            check($sformatf("g%0d checksum", g), 64'(cs[g]), 64'(csum_q[g].pop_front()));
          end
        end
        phs7 = rv[g] && rr[g] && (rs[g] == 3'd7);
        pv   = rv[g];
        pr   = rr[g];
        pd   = {rd[g], rc[g], rs[g]};
        pa   = aa[g];
        pb   = ab[g];
        pbz  = bz[g];
        psel = as[g];
      end
    end
  endtask

  task automatic seq0();
    rmode[0] = 0;
    issue(0, 8'hCA, 8'h96, 0);
    wait_until(0, 0, 3'd0, "idle");
    check("g0 stub_checksum", 64'(cs[0]), 64'h780);
    check("g0 hold_after_finish", 64'({aa[0], ab[0], as[0]}), 64'({8'hCA, 8'h96, 3'd7}));

    issue(0, 8'hCA, 8'h96, 1);
    wait_until(0, 1, 3'd0, "offer0");
    check("g0 add_first_offer", 64'({rd[0], rc[0]}), 64'({8'h60, 1'b1}));
    wait_until(0, 2, 3'd3, "drive3");
    rmode[0] = 2;
    wait_until(0, 1, 3'd3, "offer3");
    @(posedge clk); #1;
    st[0] = 1'b1; oa[0] = 8'h11; ob[0] = 8'h22;
    @(posedge clk); #1;
    st[0] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("g0 backpressure{valid,sel,res_sel}", 64'({rv[0], as[0], rs[0]}), 64'({1'b1, 3'd3, 3'd3}));
    end
    rmode[0] = 0;
    check("g0 restart_ignored_alu_a", 64'({aa[0], ab[0]}), 64'({8'hCA, 8'h96}));
    wait_until(0, 0, 3'd0, "idle");

    issue(0, 8'($urandom), 8'($urandom), 1);
    wait_until(0, 2, 3'd4, "drive4");
    rmode[0] = 2;
    wait_until(0, 1, 3'd4, "offer4");
    #2 rst_n[0] = 1'b0;
    #1;
    check("g0 reset_outputs", 64'({aa[0], ab[0], as[0], rv[0], rd[0], rc[0], rs[0], bz[0], dn[0], cs[0]}), 64'd0);
    exp_q[0].delete();
    csum_q[0].delete();
    repeat (2) @(negedge clk);
    rmode[0] = 0;
    #2 rst_n[0] = 1'b1;
    issue(0, 8'($urandom), 8'($urandom), 1);

    rmode[0] = 1;
    for (int k = 0; k < 4; k++) issue(0, 8'($urandom), 8'($urandom), 1);
    wait_until(0, 0, 3'd0, "idle");
    rmode[0] = 0;
  endtask

  task automatic seq1();
    rmode[1] = 0;
    issue(1, 8'hCA, 8'h96, 0);
    wait_until(1, 0, 3'd0, "idle");
    check("g1 stub_checksum", 64'(cs[1]), 64'h780);
    rmode[1] = 1;
    for (int k = 0; k < 3; k++) issue(1, 8'($urandom), 8'($urandom), 1);
    wait_until(1, 0, 3'd0, "idle");
    rmode[1] = 0;
  endtask

  initial begin
    for (int g = 0; g < 2; g++) begin
      rst_n[g] = 1'b0;
      st[g]    = 1'b0;
      oa[g]    = 8'd0;
      ob[g]    = 8'd0;
      rr[g]    = 1'b0;
      amode[g] = 0;
      rmode[g] = 0;
    end
    fork
      monitor(0);
      monitor(1);
      ready_drv(0);
      ready_drv(1);
    join_none
    repeat (2) @(negedge clk);
    for (int g = 0; g < 2; g++)
      check($sformatf("g%0d reset_state", g),
            64'({aa[g], ab[g], as[g], rv[g], rd[g], rc[g], rs[g], bz[g], dn[g], cs[g]}), 64'd0);
    #2;
    rst_n[0] = 1'b1;
    rst_n[1] = 1'b1;
    fork
      seq0();
      seq1();
    join
    repeat (4) @(negedge clk);
    for (int g = 0; g < 2; g++)
      check($sformatf("g%0d leftover_expected", g), 64'(exp_q[g].size() + csum_q[g].size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at 200000 ns, expected finished");
    $fatal(1, "watchdog expired");
  end

endmodule
